// File: rtl/aes_package.sv
// rtl/aes_package.sv - shared types, constants and helpers for the AES block packer
package aes_package;

  localparam int unsigned AES_WORD_W          = 32;
  localparam int unsigned AES_BLOCK_W         = 128;
  localparam int unsigned AES_WORDS_PER_BLOCK = 4;

  typedef struct packed {
    logic        start;
    logic [15:0] nb_blocks;
  } ctrl_packer_t;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic [15:0] blk_cnt;
    logic        strb_err;
  } flags_packer_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } packer_state_t;

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_block_packer.sv
// rtl/aes_block_packer.sv - packs 32-bit load-stream words into 128-bit AES state blocks
module aes_block_packer
  import aes_package::*;
#(
  parameter int unsigned WORD_W     = AES_WORD_W,
  parameter int unsigned BLOCK_W    = AES_BLOCK_W,
  parameter bit          SWAP_BYTES = 1'b0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   word_valid_i,
  output logic                   word_ready_o,
  input  logic [WORD_W-1:0]      word_data_i,
  input  logic [WORD_W/8-1:0]    word_strb_i,
  output logic                   block_valid_o,
  input  logic                   block_ready_i,
  output logic [BLOCK_W-1:0]     block_data_o,
  output logic [BLOCK_W/8-1:0]   block_strb_o,
  input  ctrl_packer_t           ctrl_i,
  output flags_packer_t          flags_o
);

  packer_state_t        state_q, state_d;
  logic [1:0]           idx_q, idx_d;
  logic [BLOCK_W-1:0]   data_q, data_d;
  logic [15:0]          nb_q, nb_d;
  logic [15:0]          cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic                 done_q, done_d;
  logic                 ready_q, ready_d;
  logic                 valid_q, valid_d;
  logic [WORD_W-1:0]    word_in;
  logic [15:0]          cnt_inc;

  assign word_in = SWAP_BYTES ? bswap32(word_data_i) : word_data_i;
  assign cnt_inc = cnt_q + 16'd1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    nb_d    = nb_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    done_d  = 1'b0;
    if (clear_i) begin
      state_d = IDLE;
      idx_d   = 2'd0;
      data_d  = '0;
      nb_d    = '0;
      cnt_d   = '0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ctrl_i.start) begin
            if (ctrl_i.nb_blocks != 16'd0) begin
              nb_d    = ctrl_i.nb_blocks;
              cnt_d   = '0;
              err_d   = 1'b0;
              state_d = FILL;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        FILL: begin
          // ready is high for the whole FILL state, so valid alone is a handshake
          if (word_valid_i) begin
            case (idx_q)
              2'd0:    data_d[BLOCK_W-1          -: WORD_W] = word_in;
              2'd1:    data_d[BLOCK_W-1-WORD_W   -: WORD_W] = word_in;
              2'd2:    data_d[BLOCK_W-1-2*WORD_W -: WORD_W] = word_in;
              default: data_d[BLOCK_W-1-3*WORD_W -: WORD_W] = word_in;
            endcase
            if (word_strb_i != '1) err_d = 1'b1;
            if (idx_q == 2'd3) begin
              idx_d   = 2'd0;
              state_d = FULL;
            end else begin
              idx_d = idx_q + 2'd1;
            end
          end
        end
        FULL: begin
          if (block_ready_i) begin
            cnt_d = cnt_inc;
            if (cnt_inc == nb_q) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = FILL;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    ready_d = (state_d == FILL);
    valid_d = (state_d == FULL);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      data_q  <= '0;
      nb_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      nb_q    <= nb_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  assign word_ready_o     = ready_q;
  assign block_valid_o    = valid_q;
  assign block_data_o     = data_q;
  assign block_strb_o     = '1;
  assign flags_o.busy     = (state_q != IDLE);
  assign flags_o.done     = done_q;
  assign flags_o.blk_cnt  = cnt_q;
  assign flags_o.strb_err = err_q;

endmodule

// File: tb/tb_aes_block_packer.sv
// tb/tb_aes_block_packer.sv - directed self-checking bench for aes_block_packer
module tb_aes_block_packer;
  import aes_package::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          word_valid = 1'b0;
  logic [31:0]   word_data = '0;
  logic [3:0]    word_strb = 4'hF;
  logic          block_ready = 1'b0;
  ctrl_packer_t  ctrl = '0;

  logic          w_ready0, b_valid0, w_ready1, b_valid1;
  logic [127:0]  b_data0, b_data1;
  logic [15:0]   b_strb0, b_strb1;
  flags_packer_t flags0, flags1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  aes_block_packer #(.SWAP_BYTES(1'b0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .word_valid_i(word_valid), .word_ready_o(w_ready0),
    .word_data_i(word_data), .word_strb_i(word_strb),
    .block_valid_o(b_valid0), .block_ready_i(block_ready),
    .block_data_o(b_data0), .block_strb_o(b_strb0),
    .ctrl_i(ctrl), .flags_o(flags0)
  );

  aes_block_packer #(.SWAP_BYTES(1'b1)) dut_swap (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .word_valid_i(word_valid), .word_ready_o(w_ready1),
    .word_data_i(word_data), .word_strb_i(word_strb),
    .block_valid_o(b_valid1), .block_ready_i(block_ready),
    .block_data_o(b_data1), .block_strb_o(b_strb1),
    .ctrl_i(ctrl), .flags_o(flags1)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [15:0] nb);
    ctrl.start = 1'b1;
    ctrl.nb_blocks = nb;
    step();
    ctrl.start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    word_valid = 1'b1;
    word_data = d;
    word_strb = s;
    while (!w_ready0 && n < 20) begin
      step();
      n++;
    end
    chk("send_ready", w_ready0, 1);
    step();
    word_valid = 1'b0;
    word_strb = 4'hF;
  endtask

  task automatic send_block(input logic [127:0] blk);
    send_word(blk[127:96], 4'hF);
    send_word(blk[95:64], 4'hF);
    send_word(blk[63:32], 4'hF);
    send_word(blk[31:0], 4'hF);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] blk;

    step();
    step();
    chk("rst_ready", w_ready0, 0);
    chk("rst_valid", b_valid0, 0);
    chk("rst_flags", flags0, '0);
    chk("rst_data", b_data0, '0);
    rst_n = 1'b1;
    step();
    chk("idle_ready", w_ready0, 0);

    // single block, no backpressure, plus byte-swapped twin
    block_ready = 1'b1;
    start_job(16'd1);
    chk("t1_busy", flags0.busy, 1);
    chk("t1_ready", w_ready0, 1);
    send_block(128'h00112233_44556677_8899AABB_CCDDEEFF);
    chk("t1_valid", b_valid0, 1);
    chk("t1_full_ready", w_ready0, 0);
    chk("t1_data", b_data0, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    chk("t1_strb", b_strb0, 16'hFFFF);
    chk("t1_swap_data", b_data1, 128'h33221100_77665544_BBAA9988_FFEEDDCC);
    step();
    chk("t1_done", flags0.done, 1);
    chk("t1_busy_fall", flags0.busy, 0);
    chk("t1_blk_cnt", flags0.blk_cnt, 16'd1);
    chk("t1_valid_fall", b_valid0, 0);
    step();
    chk("t1_done_pulse", flags0.done, 0);

    // three blocks with 10 cycles of backpressure each; a start mid-job must be ignored
    block_ready = 1'b0;
    start_job(16'd3);
    ctrl.start = 1'b1;
    ctrl.nb_blocks = 16'd1;
    step();
    ctrl.start = 1'b0;
    for (int b = 0; b < 3; b++) begin
      blk = {32'hA0000000 + 32'(b), 32'hB0000000 + 32'(b),
             32'hC0000000 + 32'(b), 32'hD0000000 + 32'(b)};
      send_block(blk);
      word_valid = 1'b1;
      word_data = 32'hDEADBEEF;
      for (int c = 0; c < 10; c++) begin
        chk("t3_hold_valid", b_valid0, 1);
        chk("t3_hold_ready", w_ready0, 0);
        chk("t3_hold_data", b_data0, blk);
        chk("t3_hold_done", flags0.done, 0);
        step();
      end
      word_valid = 1'b0;
      block_ready = 1'b1;
      step();
      block_ready = 1'b0;
      chk("t3_blk_cnt", flags0.blk_cnt, 16'(b + 1));
      chk("t3_done", flags0.done, (b == 2) ? 1 : 0);
      chk("t3_busy", flags0.busy, (b == 2) ? 0 : 1);
    end

    // strobe error on the second word
    block_ready = 1'b1;
    start_job(16'd1);
    send_word(32'h01020304, 4'hF);
    send_word(32'h05060708, 4'b0111);
    chk("t4_err_set", flags0.strb_err, 1);
    send_word(32'h090A0B0C, 4'hF);
    send_word(32'h0D0E0F10, 4'hF);
    chk("t4_valid", b_valid0, 1);
    chk("t4_data", b_data0, 128'h01020304_05060708_090A0B0C_0D0E0F10);
    step();
    chk("t4_done", flags0.done, 1);
    chk("t4_err_hold", flags0.strb_err, 1);

    // clear after two words discards the partial block
    start_job(16'd2);
    chk("t5_err_cleared", flags0.strb_err, 0);
    send_word(32'h11111111, 4'hF);
    send_word(32'h22222222, 4'hF);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("t5_busy", flags0.busy, 0);
    chk("t5_ready", w_ready0, 0);
    chk("t5_flags", flags0, '0);
    chk("t5_data", b_data0, '0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("t5_quiet", {b_valid0, flags0.done}, 0);
    end
    start_job(16'd1);
    send_block(128'h55555555_66666666_77777777_88888888);
    chk("t5_new_data", b_data0, 128'h55555555_66666666_77777777_88888888);
    step();
    chk("t5_new_done", flags0.done, 1);

    // zero-length job
    step();
    start_job(16'd0);
    chk("t6_done", flags0.done, 1);
    chk("t6_busy", flags0.busy, 0);
    chk("t6_ready", w_ready0, 0);
    step();
    chk("t6_done_pulse", flags0.done, 0);
    chk("t6_busy_after", flags0.busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_block_packer.md
Name: aes_block_packer

Overview:
Upstream stage of the AES HWPE engine datapath.
- Collects 32-bit words from the streamer's load stream into 128-bit AES state blocks.
- Presents each complete block on a 128-bit HWPE source stream to the AES engine.
- Sequenced by the HWPE controller through a ctrl/flags struct pair; counts blocks per job and reports completion and strobe errors.

Parameters:
- WORD_W, 32: input stream data width; fixed 32, other values unsupported.
- BLOCK_W, 128: output block width; must equal 4*WORD_W.
- SWAP_BYTES, 0: 1 = byte-reverse each input word before placement (little-endian memory to FIPS-197 byte order).

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset, asynchronous, active-low.
- clear_i  input  1  synchronous soft clear from the controller.
- word_i  hwpe_stream_intf_stream.sink  32 data / 4 strb  input words from the streamer.
- block_o  hwpe_stream_intf_stream.source  128 data / 16 strb  assembled AES blocks to the engine.
- ctrl_i  input  ctrl_packer_t  start (1), nb_blocks (16).
- flags_o  output  flags_packer_t  busy (1), done (1), blk_cnt (16), strb_err (1).

Behaviour:
- Reset: state IDLE; word index 0; block register 0; block_o.valid 0; word_i.ready 0; all flags 0.
- FSM states:
  - IDLE
    - word_i.ready=0; block_o.valid=0.
    - ctrl_i.start with nb_blocks!=0: latch nb_blocks, clear blk_cnt and strb_err, go to FILL.
    - start with nb_blocks==0: pulse done for 1 cycle, stay IDLE.
  - FILL
    - word_i.ready=1.
    - Each handshake (valid&ready) writes the (optionally byte-swapped) word into slot idx and increments idx.
    - Slot 0 maps to bits [127:96], slot 1 to [95:64], slot 2 to [63:32], slot 3 to [31:0].
    - Handshake with idx==3: idx wraps to 0, go to FULL.
  - FULL
    - block_o.valid=1; block_o.strb='1; word_i.ready=0.
    - block_o.data holds stable until handshake.
    - On block_o.ready: blk_cnt++. If blk_cnt+1==latched nb_blocks, pulse done and go to IDLE; otherwise go to FILL.
- Latency: block_o.valid rises the cycle after the 4th word handshake. Steady-state throughput is 1 block per 5 cycles with no backpressure.
- No combinational path from block_o.ready to word_i.ready; word_i.ready depends only on state.
- Strobe: a word accepted with strb!='1 is still stored, and strb_err sets and stays set until the next start or clear.
- busy = (state != IDLE).
- done is a single-cycle pulse.
- blk_cnt is a 16-bit counter reporting blocks delivered in the current job. It does not wrap within a job, since it is bounded by nb_blocks.
- start while busy is ignored; the latched count is unchanged.
- clear_i takes priority over all other events in the same cycle: state IDLE, idx 0, block register 0, flags 0. A partially filled block is discarded and no done pulse is issued.
- Async reset mid-job: same end state as clear. An in-flight block is lost.
- word_i.valid in IDLE or FULL: not accepted (ready=0); the upstream must hold it.
- Simultaneous block_o handshake on the last block and start: the start is ignored, because the FSM is in FULL, not IDLE.

Decomposition:
- aes_package gets:
  - Constants AES_WORD_W=32, AES_BLOCK_W=128, AES_WORDS_PER_BLOCK=4.
  - ctrl_packer_t {start; nb_blocks[15:0]}.
  - flags_packer_t {busy; done; blk_cnt[15:0]; strb_err}.
  - Enum packer_state_t {IDLE, FILL, FULL}.
  - Function bswap32.
- Single module, no sub-module needed; the FSM and word register fit in one file.

Test Plan:
- nb_blocks=1, words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF back-to-back, SWAP_BYTES=0, block_o.ready=1 -> block_o.data=0x00112233_44556677_8899AABB_CCDDEEFF one cycle after the 4th handshake; done pulses; blk_cnt=1; busy falls.
- SWAP_BYTES=1, first word 0x00112233 -> bits [127:96]=0x33221100.
- nb_blocks=3, block_o.ready held 0 for 10 cycles on each block -> word_i.ready=0 throughout FULL; data stable; exactly 3 block handshakes; done only after the 3rd; blk_cnt=3.
- Second word sent with strb=4'b0111 -> block still emitted; strb_err=1 until the next start.
- clear_i asserted after 2 words of a nb_blocks=2 job -> IDLE next cycle; no block_o.valid; no done. A new start with 4 words yields a block containing only the new words.
- start with nb_blocks=0 -> one-cycle done pulse; busy stays 0; word_i.ready stays 0.
